bandit_scheduler: RTL and testbench

- Shares one `action_value` bandit agent among N environment ports using round-robin arbitration.
- Grants one environment per transaction.
- Routes the agent's action to the granted environment, then routes that environment's reward back to the agent.
- If an environment never answers, injects a penalty reward after a timeout so the agent cannot deadlock.
- Sits between the agent's action/reward streams and the environment interfaces.

---
 rtl/bandit_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_bandit_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bandit_scheduler.sv
// -----------------------------------------------------------------------------
// bandit_scheduler
//
// Shares one action_value bandit agent among N environment ports. Ports are
// served one transaction at a time in round-robin order. A transaction moves
// the agent's action to the granted port, then carries that port's reward
// back to the agent. If the port never answers, a fixed penalty reward is
// offered to the agent after TIMEOUT observing cycles so the agent can never
// deadlock.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   agent_action_*          action stream from the agent (valid/data/ready)
//   agent_action_gready     greedy-only flag of the granted port (1 when idle)
//   agent_reward_*          reward stream to the agent (valid/data/ready)
//   env_request[N]          per-port request for an action
//   env_gready[N]           per-port greedy-only flag
//   env_action_*            per-port action offer, data broadcast to all ports
//   env_reward_*            per-port reward stream, port i on data[8i+7:8i]
//   grant[N]                one-hot granted port, zero when idle
//   timeout                 one-cycle pulse after the penalty is accepted
// -----------------------------------------------------------------------------
module bandit_scheduler #(
    parameter int         N       = 4,
    parameter int         TIMEOUT = 255,
    parameter logic [7:0] PENALTY = 8'h80
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             agent_action_valid,
    input  logic [7:0]       agent_action_data,
    output logic             agent_action_ready,
    output logic             agent_action_gready,
    output logic             agent_reward_valid,
    output logic [7:0]       agent_reward_data,
    input  logic             agent_reward_ready,
    input  logic [N-1:0]     env_request,
    input  logic [N-1:0]     env_gready,
    output logic [N-1:0]     env_action_valid,
    output logic [7:0]       env_action_data,
    input  logic [N-1:0]     env_action_ready,
    input  logic [N-1:0]     env_reward_valid,
    input  logic [8*N-1:0]   env_reward_data,
    output logic [N-1:0]     env_reward_ready,
    output logic [N-1:0]     grant,
    output logic             timeout
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    // Timer must hold the value TIMEOUT itself; TIMEOUT=0 still needs 1 bit.
    localparam int TW = $clog2(TIMEOUT + 2);

    localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT);
    localparam logic [LW-1:0] LAST_RST_C = LW'(N - 1);
    localparam logic [N-1:0]  ONE_C      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTUATING = 2'd1,
        OBSERVING = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [N-1:0]    grant_r;
    logic [N-1:0]    grant_next_s;
    logic [LW-1:0]   gidx_r;
    logic [LW-1:0]   gidx_next_s;
    logic [LW-1:0]   last_r;
    logic [LW-1:0]   last_next_s;
    logic [TW-1:0]   timer_r;
    logic [TW-1:0]   timer_next_s;
    logic            timeout_r;
    logic            timeout_next_s;

    logic [LW-1:0]   rr_pick_s;
    logic            rr_found_s;
    logic [7:0]      env_rew_data_s;
    logic            penalty_s;

    // Port index reached by stepping 'off' places after 'base', wrapping at N.
    function automatic logic [LW-1:0] rr_idx(input logic [LW-1:0] base,
                                             input int            off);
        int sum;
        sum = (int'(base) + off) % N;
        return LW'(sum);
    endfunction

    // Round-robin search: first requesting port strictly after the last served one.
    always_comb begin
        rr_pick_s  = '0;
        rr_found_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found_s && env_request[rr_idx(last_r, k)]) begin
                rr_found_s = 1'b1;
                rr_pick_s  = rr_idx(last_r, k);
            end else begin
                rr_pick_s  = rr_pick_s;
            end
        end
    end

    // Reward lane of the currently granted port.
    always_comb begin
        env_rew_data_s = env_reward_data[int'(gidx_r) * 8 +: 8];
    end

    // Action data is broadcast; only the granted port's valid qualifies it.
    always_comb begin
        env_action_data = agent_action_data;
    end

    // Next-state logic and all handshake routing.
    always_comb begin
        state_next_s        = state_r;
        grant_next_s        = grant_r;
        gidx_next_s         = gidx_r;
        last_next_s         = last_r;
        timer_next_s        = timer_r;
        timeout_next_s      = 1'b0;
        penalty_s           = 1'b0;
        agent_action_ready  = 1'b0;
        agent_action_gready = 1'b1;
        agent_reward_valid  = 1'b0;
        agent_reward_data   = 8'h00;
        env_action_valid    = '0;
        env_reward_ready    = '0;

        case (state_r)
            IDLE: begin
                if (rr_found_s) begin
                    state_next_s = ACTUATING;
                    grant_next_s = ONE_C << rr_pick_s;
                    gidx_next_s  = rr_pick_s;
                end else begin
                    state_next_s = IDLE;
                end
            end

            ACTUATING: begin
                agent_action_gready      = env_gready[gidx_r];
                env_action_valid[gidx_r] = agent_action_valid;
                agent_action_ready       = env_action_ready[gidx_r];
                if (agent_action_valid && env_action_ready[gidx_r]) begin
                    state_next_s = OBSERVING;
                    timer_next_s = '0;
                end else begin
                    state_next_s = ACTUATING;
                end
            end

            OBSERVING: begin
                agent_action_gready = env_gready[gidx_r];
                // A real reward always beats an expiring timer.
                if (env_reward_valid[gidx_r]) begin
                    agent_reward_valid       = 1'b1;
                    agent_reward_data        = env_rew_data_s;
                    env_reward_ready[gidx_r] = agent_reward_ready;
                end else if ((TIMEOUT != 0) && (timer_r == TIMEOUT_C)) begin
                    agent_reward_valid = 1'b1;
                    agent_reward_data  = PENALTY;
                    penalty_s          = 1'b1;
                end else begin
                    agent_reward_valid = 1'b0;
                end

                if (agent_reward_valid && agent_reward_ready) begin
                    state_next_s   = IDLE;
                    last_next_s    = gidx_r;
                    grant_next_s   = '0;
                    timeout_next_s = penalty_s;
                end else begin
                    state_next_s = OBSERVING;
                    // Timer saturates at TIMEOUT so the penalty stays offered.
                    if ((TIMEOUT != 0) && (timer_r != TIMEOUT_C)) begin
                        timer_next_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                    end else begin
                        timer_next_s = timer_r;
                    end
                end
            end

            default: begin
                state_next_s = IDLE;
                grant_next_s = '0;
                gidx_next_s  = '0;
                timer_next_s = '0;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            gidx_r    <= '0;
            last_r    <= LAST_RST_C;
            timer_r   <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            grant_r   <= grant_next_s;
            gidx_r    <= gidx_next_s;
            last_r    <= last_next_s;
            timer_r   <= timer_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    // Registered status outputs.
    always_comb begin
        grant   = grant_r;
        timeout = timeout_r;
    end

endmodule

// File: tb/tb_bandit_scheduler.sv
module tb_bandit_scheduler;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           agent_action_valid = 1'b0;
    logic [7:0]     agent_action_data  = 8'h00;
    logic           agent_action_ready;
    logic           agent_action_gready;
    logic           agent_reward_valid;
    logic [7:0]     agent_reward_data;
    logic           agent_reward_ready = 1'b0;
    logic [N-1:0]   env_request        = '0;
    logic [N-1:0]   env_gready         = '0;
    logic [N-1:0]   env_action_valid;
    logic [7:0]     env_action_data;
    logic [N-1:0]   env_action_ready   = '0;
    logic [N-1:0]   env_reward_valid   = '0;
    logic [8*N-1:0] env_reward_data    = '0;
    logic [N-1:0]   env_reward_ready;
    logic [N-1:0]   grant;
    logic           timeout;

    always #5 clock = ~clock;

    bandit_scheduler #(.N(N), .TIMEOUT(TMO), .PENALTY(8'h80)) dut (
        .clock               (clock),
        .reset               (reset),
        .agent_action_valid  (agent_action_valid),
        .agent_action_data   (agent_action_data),
        .agent_action_ready  (agent_action_ready),
        .agent_action_gready (agent_action_gready),
        .agent_reward_valid  (agent_reward_valid),
        .agent_reward_data   (agent_reward_data),
        .agent_reward_ready  (agent_reward_ready),
        .env_request         (env_request),
        .env_gready          (env_gready),
        .env_action_valid    (env_action_valid),
        .env_action_data     (env_action_data),
        .env_action_ready    (env_action_ready),
        .env_reward_valid    (env_reward_valid),
        .env_reward_data     (env_reward_data),
        .env_reward_ready    (env_reward_ready),
        .grant               (grant),
        .timeout             (timeout)
    );

    typedef struct { int port; logic [7:0] data; } act_exp_t;
    typedef struct { int port; logic [7:0] data; bit pen; } rew_exp_t;

    act_exp_t act_q[$];
    rew_exp_t rew_q[$];

    int nchk = 0;
    int nerr = 0;
    int m_last = N - 1;       // reference model: last served port
    bit tmo_pending = 1'b0;
    bit tmo_exp = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [N-1:0] onehot(input int p);
        logic [N-1:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference arbiter: scan ports after the last served one, wrapping.
    function automatic int model_pick(input logic [N-1:0] req);
        for (int k = 1; k <= N; k++) begin
            if (req[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    // Monitor: pops expectations on every handshake and checks routing rules.
    initial begin
        act_exp_t ae;
        rew_exp_t re;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (tmo_pending) check("timeout_pulse", 32'(timeout), 32'(tmo_exp));
                else if (timeout) check("timeout_spurious", 32'(timeout), 32'd0);
                tmo_pending = 1'b0;

                check("action_fanout", 32'(env_action_valid), 32'(grant & {N{agent_action_valid}}));
                check("action_ready_route", 32'(agent_action_ready), 32'(|(grant & env_action_ready)));
                check("reward_ready_route", 32'(env_reward_ready),
                      32'(grant & env_reward_valid & {N{agent_reward_ready}}));
                check("action_bcast", 32'(env_action_data), 32'(agent_action_data));

                if (|(env_action_valid & env_action_ready)) begin
                    if (act_q.size() == 0) begin
                        check("action_unexpected", 32'd1, 32'd0);
                    end else begin
                        ae = act_q.pop_front();
                        check("action_grant", 32'(grant), 32'(onehot(ae.port)));
                        check("action_data", 32'(env_action_data), 32'(ae.data));
                    end
                end

                if (agent_reward_valid && agent_reward_ready) begin
                    if (rew_q.size() == 0) begin
                        check("reward_unexpected", 32'd1, 32'd0);
                    end else begin
                        re = rew_q.pop_front();
                        check("reward_grant", 32'(grant), 32'(onehot(re.port)));
                        check("reward_data_hs", 32'(agent_reward_data), 32'(re.data));
                        tmo_pending = 1'b1;
                        tmo_exp     = re.pen;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction driven from the model's view of the schedule.
    // d: OBSERVING cycle the env raises its reward, r: cycle the agent becomes
    // ready, da: extra ACTUATING cycles before the env accepts the action.
    task automatic run_txn(input logic [N-1:0] req, input logic [7:0] act, input logic [N-1:0] gr,
                           input bit env_ans, input int d, input int r, input int da,
                           input logic [7:0] v, input bit drop);
        int p;
        int h;
        bit exp_rv;
        logic [N-1:0] oh;
        logic [7:0] exp_data;
        act_exp_t ae;
        rew_exp_t re;

        env_request = req;
        env_gready  = gr;
        #3;
        check("idle_grant", 32'(grant), 32'd0);
        check("idle_gready", 32'(agent_action_gready), 32'd1);
        check("idle_reward_valid", 32'(agent_reward_valid), 32'd0);
        p  = model_pick(req);
        oh = onehot(p);
        ae.port = p;
        ae.data = act;
        act_q.push_back(ae);
        step();

        for (int k = 1; k <= da + 1; k++) begin
            agent_action_valid = 1'b1;
            agent_action_data  = act;
            env_action_ready   = (N'($urandom) & ~oh) | ((k == da + 1) ? oh : '0);
            env_reward_valid   = N'($urandom) & ~oh;
            if (drop) env_request = '0;
            #3;
            if (k == 1) begin
                check("grant_latency", 32'(grant), 32'(oh));
                check("granted_gready", 32'(agent_action_gready), 32'(gr[p]));
            end
            step();
        end
        agent_action_valid = 1'b0;
        env_action_ready   = '0;
        agent_action_data  = 8'($urandom);

        exp_data = env_ans ? v : 8'h80;
        h = env_ans ? imax(d, r) : imax(TMO + 1, r);
        re.port = p;
        re.data = exp_data;
        re.pen  = !env_ans;
        rew_q.push_back(re);

        for (int o = 1; o <= h; o++) begin
            env_reward_valid = (N'($urandom) & ~oh) | ((env_ans && o >= d) ? oh : '0);
            env_reward_data  = 32'($urandom);
            env_reward_data[8*p +: 8] = v;
            agent_reward_ready = (o >= r);
            #3;
            exp_rv = env_ans ? (o >= d) : (o >= TMO + 1);
            check("reward_valid", 32'(agent_reward_valid), 32'(exp_rv));
            if (exp_rv) check("reward_data", 32'(agent_reward_data), 32'(exp_data));
            check("grant_hold", 32'(grant), 32'(oh));
            check("observe_gready", 32'(agent_action_gready), 32'(gr[p]));
            step();
        end
        env_reward_valid   = '0;
        agent_reward_ready = 1'b0;
        m_last = p;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_env_action_valid"}, 32'(env_action_valid), 32'd0);
        check({tag, "_env_reward_ready"}, 32'(env_reward_ready), 32'd0);
        check({tag, "_agent_action_ready"}, 32'(agent_action_ready), 32'd0);
        check({tag, "_agent_reward_valid"}, 32'(agent_reward_valid), 32'd0);
        check({tag, "_agent_reward_data"}, 32'(agent_reward_data), 32'd0);
        check({tag, "_gready"}, 32'(agent_action_gready), 32'd1);
        check({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    // Reset in the middle of OBSERVING, while a reward is pending.
    task automatic reset_mid();
        act_exp_t ae;
        env_request = 4'b0100;
        env_gready  = 4'b1111;
        ae.port = model_pick(4'b0100);
        ae.data = 8'h77;
        act_q.push_back(ae);
        step();
        agent_action_valid = 1'b1;
        agent_action_data  = 8'h77;
        env_action_ready   = 4'b0100;
        step();
        agent_action_valid = 1'b0;
        env_action_ready   = '0;
        env_request        = '0;
        step();
        env_reward_valid   = 4'b0100;
        env_reward_data    = 32'h0033_0000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        env_reward_valid = '0;
        #3;
        check_reset_values("mid_reset");
        m_last = N - 1;
        step();
    endtask

    initial begin
        repeat (2) step();
        #3;
        check_reset_values("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Round-robin fairness from reset: order 0,1,2,3,0,1,2,3, 3-cycle period.
        for (int i = 0; i < 8; i++)
            run_txn(4'b1111, 8'($urandom), 4'b1111, 1'b1, 1, 1, 0, 8'($urandom), 1'b0);

        // Single requester.
        run_txn(4'b0100, 8'h2a, 4'b1111, 1'b1, 1, 1, 0, 8'h05, 1'b0);
        // Timeout: env never answers.
        run_txn(4'b0010, 8'h11, 4'b1111, 1'b0, 1, 1, 0, 8'h00, 1'b0);
        // Race: env reward on the cycle the timer reaches TIMEOUT.
        run_txn(4'b1000, 8'h22, 4'b1111, 1'b1, TMO + 1, 1, 0, 8'h10, 1'b0);
        // Agent backpressure for 3 cycles.
        run_txn(4'b0001, 8'h33, 4'b1111, 1'b1, 1, 4, 0, 8'hf3, 1'b0);
        // Request withdrawn in ACTUATING.
        run_txn(4'b0100, 8'h44, 4'b1111, 1'b1, 2, 1, 1, 8'h7f, 1'b1);
        // Granted port not greedy-only.
        run_txn(4'b1000, 8'h55, 4'b0111, 1'b1, 1, 1, 0, 8'h81, 1'b0);
        // Penalty held while agent stalls.
        run_txn(4'b0110, 8'h66, 4'b1111, 1'b0, 1, 7, 0, 8'h00, 1'b0);

        // Reset mid-transaction, then port 0 must win first.
        reset_mid();
        run_txn(4'b1111, 8'h99, 4'b1110, 1'b1, 1, 1, 0, 8'h42, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++)
            run_txn(N'($urandom_range(1, 15)), 8'($urandom), N'($urandom),
                    ($urandom_range(0, 3) != 0), $urandom_range(1, TMO + 1),
                    $urandom_range(1, 7), $urandom_range(0, 2), 8'($urandom),
                    1'($urandom_range(0, 1)));

        step();
        step();
        check("act_q_drained", 32'(act_q.size()), 32'd0);
        check("rew_q_drained", 32'(rew_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
